// File: rtl/ps2_pkg.sv
// Shared constants and state encoding for the PS/2 Set-2 scan-code decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT         = 8'hE0;
  localparam logic [7:0] PS2_BRK         = 8'hF0;
  localparam logic [7:0] PS2_PAUSE       = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK      = 8'hAA;
  localparam logic [7:0] PS2_ERR         = 8'hFC;
  localparam logic [7:0] PS2_ERR_00      = 8'h00;
  localparam logic [7:0] PS2_ERR_FF      = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;
  localparam logic [7:0] PS2_ECHO        = 8'hEE;
  localparam logic [7:0] PS2_RESEND      = 8'hFE;
  localparam logic [7:0] PS2_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_FAKE_RSHIFT = 8'h59;

  localparam int PAUSE_TAIL_LEN = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == PS2_FAKE_LSHIFT) || (b == PS2_FAKE_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / key-event-out bundle between the PS/2 receive path and the decoder.
interface ps2_scancode_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       bat_ok;
  logic       kb_err;

  modport master (
    output rx_data, rx_done,
    input  key_valid, key_code, key_ext, key_break, bat_ok, kb_err
  );

  modport slave (
    input  rx_data, rx_done,
    output key_valid, key_code, key_ext, key_break, bat_ok, kb_err
  );
endinterface

// File: rtl/ps2_seq_timer.sv
// Inter-byte watchdog: counts while enabled, expire is high on the last allowed cycle.
module ps2_seq_timer #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
  end

  // clear masks expiry so a byte arriving on the final cycle takes priority
  assign expire = enable && !clear && (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code sequence decoder: one key event per make/break, Pause, BAT and error reporting.
// Optional PS2_TYPEMATIC_FILTER_EN drops auto-repeat makes of the currently held key.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input logic                  clk,
  input logic                  rst,
  ps2_scancode_decoder_if.slave bus
);

  state_t     state;
  logic       rx_done_q;
  logic       byte_acc;
  logic [2:0] pause_cnt;
  logic       expire;
  logic       emit_now;
  logic       drop;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;

  assign byte_acc = bus.rx_done & ~rx_done_q;

  ps2_seq_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (byte_acc | (state == S_IDLE)),
    .enable (state != S_IDLE),
    .expire (expire)
  );

  assign ev_code = (state == S_PAUSE) ? PS2_PAUSE : bus.rx_data;
  assign ev_ext  = (state == S_EXT) || (state == S_EXT_BRK);
  assign ev_brk  = (state == S_BRK) || (state == S_EXT_BRK);

  always_comb begin
    emit_now = 1'b0;
    if (byte_acc) begin
      case (state)
        S_IDLE: begin
          case (bus.rx_data)
            PS2_EXT, PS2_BRK, PS2_PAUSE, PS2_BAT_OK, PS2_ERR, PS2_ERR_00,
            PS2_ERR_FF, PS2_ACK, PS2_ECHO, PS2_RESEND: emit_now = 1'b0;
            default:                                   emit_now = 1'b1;
          endcase
        end
        S_EXT:     emit_now = (bus.rx_data != PS2_BRK) && !is_fake_shift(bus.rx_data);
        S_BRK:     emit_now = 1'b1;
        S_EXT_BRK: emit_now = !is_fake_shift(bus.rx_data);
        S_PAUSE:   emit_now = (pause_cnt == 3'd1);
        default:   emit_now = 1'b0;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_vld;
  logic [7:0] held_code;
  logic       held_ext;
  logic       held_match;

  assign held_match = held_vld && (held_code == ev_code) && (held_ext == ev_ext);
  assign drop       = !ev_brk && held_match;
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rx_done_q     <= 1'b0;
      pause_cnt     <= '0;
      bus.key_valid <= 1'b0;
      bus.key_code  <= '0;
      bus.key_ext   <= 1'b0;
      bus.key_break <= 1'b0;
      bus.bat_ok    <= 1'b0;
      bus.kb_err    <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_vld      <= 1'b0;
      held_code     <= '0;
      held_ext      <= 1'b0;
`endif
    end else begin
      rx_done_q     <= bus.rx_done;
      bus.key_valid <= 1'b0;
      bus.bat_ok    <= 1'b0;
      bus.kb_err    <= 1'b0;

      if (emit_now && !drop) begin
        bus.key_valid <= 1'b1;
        bus.key_code  <= ev_code;
        bus.key_ext   <= ev_ext;
        bus.key_break <= ev_brk;
      end

`ifdef PS2_TYPEMATIC_FILTER_EN
      if (emit_now) begin
        if (!ev_brk) begin
          held_vld  <= 1'b1;
          held_code <= ev_code;
          held_ext  <= ev_ext;
        end else if (held_match) begin
          held_vld  <= 1'b0;
        end
      end
`endif

      if (byte_acc) begin
        case (state)
          S_IDLE: begin
            case (bus.rx_data)
              PS2_EXT:   state <= S_EXT;
              PS2_BRK:   state <= S_BRK;
              PS2_PAUSE: begin
                state     <= S_PAUSE;
                pause_cnt <= 3'(PAUSE_TAIL_LEN);
              end
              PS2_BAT_OK:                    bus.bat_ok <= 1'b1;
              PS2_ERR, PS2_ERR_00, PS2_ERR_FF: bus.kb_err <= 1'b1;
              default: ;
            endcase
          end
          S_EXT:     state <= (bus.rx_data == PS2_BRK) ? S_EXT_BRK : S_IDLE;
          S_BRK:     state <= S_IDLE;
          S_EXT_BRK: state <= S_IDLE;
          S_PAUSE: begin
            pause_cnt <= pause_cnt - 3'd1;
            if (pause_cnt == 3'd1) state <= S_IDLE;
          end
          default:   state <= S_IDLE;
        endcase
      end else if (expire) begin
        bus.kb_err <= 1'b1;
        state      <= S_IDLE;
        pause_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a short sequence timeout.
module tb_ps2_scancode_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  int ev_cnt = 0;
  int bat_cnt = 0;
  int err_cnt = 0;
  int base_ev, base_bat, base_err;

  logic       c_kv, c_ext, c_brk, c_bat, c_err;
  logic [7:0] c_code;

  ps2_scancode_decoder_if bus ();

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.key_valid) ev_cnt++;
    if (bus.bat_ok)    bat_cnt++;
    if (bus.kb_err)    err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte, capture outputs the cycle after acceptance, then one low cycle.
  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    c_kv   = bus.key_valid;
    c_code = bus.key_code;
    c_ext  = bus.key_ext;
    c_brk  = bus.key_break;
    c_bat  = bus.bat_ok;
    c_err  = bus.kb_err;
    @(posedge clk); #1;
  endtask

  task automatic mark();
    base_ev  = ev_cnt;
    base_bat = bat_cnt;
    base_err = err_cnt;
  endtask

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_key_valid", bus.key_valid, 0);
    chk("rst_key_code",  bus.key_code, 0);
    chk("rst_key_ext",   bus.key_ext, 0);
    chk("rst_key_break", bus.key_break, 0);
    chk("rst_bat_ok",    bus.bat_ok, 0);
    chk("rst_kb_err",    bus.kb_err, 0);

    // plain make, then break
    mark();
    send(8'h1C);
    chk("make_valid", c_kv, 1);
    chk("make_code",  c_code, 8'h1C);
    chk("make_ext",   c_ext, 0);
    chk("make_brk",   c_brk, 0);
    chk("make_pulse_len", ev_cnt - base_ev, 1);
    mark();
    send(8'hF0);
    chk("brk_prefix_silent", c_kv, 0);
    send(8'h1C);
    chk("brk_valid", c_kv, 1);
    chk("brk_code",  c_code, 8'h1C);
    chk("brk_ext",   c_ext, 0);
    chk("brk_brk",   c_brk, 1);
    chk("brk_events", ev_cnt - base_ev, 1);

    // extended make / break / fake shift
    send(8'hE0);
    send(8'h75);
    chk("ext_make_valid", c_kv, 1);
    chk("ext_make_code",  c_code, 8'h75);
    chk("ext_make_ext",   c_ext, 1);
    chk("ext_make_brk",   c_brk, 0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("ext_brk_code", c_code, 8'h75);
    chk("ext_brk_ext",  c_ext, 1);
    chk("ext_brk_brk",  c_brk, 1);
    mark();
    send(8'hE0);
    send(8'h12);
    send(8'hE0);
    send(8'hF0);
    send(8'h59);
    chk("fake_shift_events", ev_cnt - base_ev, 0);

    // Pause sequence
    mark();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0);
    chk("pause_no_early", ev_cnt - base_ev, 0);
    send(8'h77);
    chk("pause_valid", c_kv, 1);
    chk("pause_code",  c_code, 8'hE1);
    chk("pause_ext",   c_ext, 0);
    chk("pause_brk",   c_brk, 0);
    chk("pause_events", ev_cnt - base_ev, 1);

    // status bytes
    mark();
    send(8'hAA);
    chk("bat_pulse", c_bat, 1);
    chk("bat_no_key", c_kv, 0);
    send(8'hFC);
    chk("err_pulse", c_err, 1);
    send(8'hFA);
    chk("ack_ignored_ev", ev_cnt - base_ev, 0);
    chk("status_bat_cnt", bat_cnt - base_bat, 1);
    chk("status_err_cnt", err_cnt - base_err, 1);

    // level rx_done held high: single byte
    mark();
    bus.rx_data = 8'h2B;
    bus.rx_done = 1'b1;
    repeat (10) @(posedge clk);
    #1 bus.rx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("level_one_event", ev_cnt - base_ev, 1);
    chk("level_code", bus.key_code, 8'h2B);

    // sequence timeout
    mark();
    send(8'hE0);
    repeat (20) @(posedge clk);
    #1;
    chk("timeout_err", err_cnt - base_err, 1);
    chk("timeout_no_event", ev_cnt - base_ev, 0);
    send(8'h1C);
    chk("after_timeout_code", c_code, 8'h1C);
    chk("after_timeout_ext",  c_ext, 0);

    // byte landing on the expiry cycle wins
    mark();
    send(8'hE0);
    repeat (14) @(posedge clk);
    #1;
    send(8'h75);
    chk("expiry_byte_valid", c_kv, 1);
    chk("expiry_byte_ext",   c_ext, 1);
    chk("expiry_byte_code",  c_code, 8'h75);
    repeat (20) @(posedge clk);
    #1;
    chk("expiry_byte_no_err", err_cnt - base_err, 0);

    // reset mid-sequence
    mark();
    send(8'hF0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_no_event", ev_cnt - base_ev, 0);
    chk("rst_mid_no_err", err_cnt - base_err, 0);
    send(8'h1C);
    chk("rst_mid_make_brk", c_brk, 0);
    chk("rst_mid_make_code", c_code, 8'h1C);
    send(8'hF0);
    send(8'h1C);

    // typematic repeats
    mark();
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("typematic_events", ev_cnt - base_ev, 2);
`else
    chk("typematic_events", ev_cnt - base_ev, 4);
`endif
    chk("typematic_last_brk", bus.key_break, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
